// File: rtl/univ_shreg_pkg.sv
// univ_shreg_pkg: shared op and state encodings for the universal shift register
package univ_shreg_pkg;
  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHR  = 3'b010,
    OP_SHL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_CLR  = 3'b110,
    OP_NOP  = 3'b111
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_TX, S_RX} state_e;
endpackage

// File: rtl/shreg_core.sv
// shreg_core: WIDTH-bit shift/rotate/load register datapath
module shreg_core
  import univ_shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  op_e              op,
  input  logic [WIDTH-1:0] pin,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] d;
  always_comb begin
    d = q;
    case (op)
      OP_LOAD: d = pin;
      OP_SHR:  d = {sin, q[WIDTH-1:1]};
      OP_SHL:  d = {q[WIDTH-2:0], sin};
      OP_ROR:  d = {q[0], q[WIDTH-1:1]};
      OP_ROL:  d = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_CLR:  d = '0;
      default: d = q;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= d;
endmodule

// File: rtl/univ_shreg_ctrl.sv
// univ_shreg_ctrl: universal shift register with counted serial TX/RX frame sequencer
module univ_shreg_ctrl
  import univ_shreg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] pin,
  input  logic             sin,
  input  logic             tx_start,
  input  logic             rx_start,
  input  logic             abort,
  output logic [WIDTH-1:0] pout,
  output logic             so,
  output logic             so_valid,
  output logic             po_valid,
  output logic             done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           last, rx_done;
  op_e            core_op, shift_op;
  logic           core_sin;
  assign last = cnt == CW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rx_done <= state == S_RX && last && !abort;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE:
        if (tx_start || rx_start) begin
          state_n = tx_start ? S_TX : S_RX;
          cnt_n   = CW'(WIDTH);
        end
      default:
        if (abort) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt - CW'(1);
          state_n = last ? S_IDLE : state;
        end
    endcase
  end
  // Frames always shift toward the so end; TX fills with zeros, RX with sin.
  always_comb begin
    shift_op = LSB_FIRST ? OP_SHR : OP_SHL;
    core_op  = state == S_IDLE ? (tx_start ? OP_LOAD : rx_start ? OP_HOLD : op_e'(op))
                               : abort ? OP_HOLD : shift_op;
    core_sin = state == S_TX ? 1'b0 : sin;
    so_valid = state == S_TX;
    busy     = state != S_IDLE;
    po_valid = rx_done;
    done     = rx_done || (state == S_TX && last && !abort);
  end
  shreg_core #(.WIDTH(WIDTH)) u_core (
    .clk (clk),
    .rst (rst),
    .op  (core_op),
    .pin (pin),
    .sin (core_sin),
    .q   (pout)
  );
  assign so = LSB_FIRST ? pout[0] : pout[WIDTH-1];
endmodule

// File: tb/tb_univ_shreg_ctrl.sv
// tb_univ_shreg_ctrl: vectors, directed frame sequences and random model check of both bit orders
module tb_univ_shreg_ctrl;
  logic clk = 0, rst = 1;
  logic [2:0] op = 0;
  logic [7:0] pin = 0;
  logic sin = 0, tx_start = 0, rx_start = 0, abort = 0;
  logic [7:0] pout_l, pout_m;
  logic [1:0] so_v, sv_v, pv_v, dn_v, bz_v;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  univ_shreg_ctrl #(.WIDTH(8), .LSB_FIRST(1)) dut_l (
    .clk(clk), .rst(rst), .op(op), .pin(pin), .sin(sin), .tx_start(tx_start),
    .rx_start(rx_start), .abort(abort), .pout(pout_l), .so(so_v[0]),
    .so_valid(sv_v[0]), .po_valid(pv_v[0]), .done(dn_v[0]), .busy(bz_v[0]));
  univ_shreg_ctrl #(.WIDTH(8), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst(rst), .op(op), .pin(pin), .sin(sin), .tx_start(tx_start),
    .rx_start(rx_start), .abort(abort), .pout(pout_m), .so(so_v[1]),
    .so_valid(sv_v[1]), .po_valid(pv_v[1]), .done(dn_v[1]), .busy(bz_v[1]));
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic nx();
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic [2:0] op;
    logic [7:0] pin;
    logic       sin;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[9];
  logic [7:0] mq[2];
  int mm[2], mk[2];
  bit mp[2];
  initial begin
    logic [7:0] w;
    int n, pulses;
    tbl[0] = '{3'b001, 8'h81, 1'b0, 8'h81};
    tbl[1] = '{3'b101, 8'h00, 1'b0, 8'h03};
    tbl[2] = '{3'b010, 8'h00, 1'b1, 8'h81};
    tbl[3] = '{3'b011, 8'h00, 1'b0, 8'h02};
    tbl[4] = '{3'b110, 8'hFF, 1'b1, 8'h00};
    tbl[5] = '{3'b001, 8'h01, 1'b0, 8'h01};
    tbl[6] = '{3'b100, 8'h00, 1'b0, 8'h80};
    tbl[7] = '{3'b000, 8'hFF, 1'b1, 8'h80};
    tbl[8] = '{3'b111, 8'hFF, 1'b1, 8'h80};
    #2;
    chk("rst pout_l", pout_l, 0);
    chk("rst pout_m", pout_m, 0);
    chk("rst so", so_v, 0);
    chk("rst so_valid", sv_v, 0);
    chk("rst po_valid", pv_v, 0);
    chk("rst done", dn_v, 0);
    chk("rst busy", bz_v, 0);
    nx();
    rst = 0;
    for (int i = 0; i < 9; i++) begin
      op = tbl[i].op; pin = tbl[i].pin; sin = tbl[i].sin;
      nx();
      chk($sformatf("op%0d pout_l", i), pout_l, tbl[i].exp);
      chk($sformatf("op%0d pout_m", i), pout_m, tbl[i].exp);
      chk($sformatf("op%0d busy", i), bz_v, 0);
    end
    op = 0; sin = 0;
    // LSB-first transmit of A5
    w = 8'hA5; pin = w; tx_start = 1;
    nx();
    tx_start = 0; pin = 0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("tx%0d so_valid", k), sv_v[0], 1);
      chk($sformatf("tx%0d so", k), so_v[0], w[k]);
      chk($sformatf("tx%0d done", k), dn_v[0], k == 7);
      nx();
    end
    chk("tx end so_valid", sv_v, 0);
    chk("tx end busy", bz_v, 0);
    chk("tx end done", dn_v, 0);
    // receive stream 0,1,1,0,1,0,0,1
    w = 8'h96; rx_start = 1;
    nx();
    rx_start = 0; pulses = 0;
    for (int k = 0; k < 8; k++) begin
      sin = w[k];
      #1;
      pulses += int'(pv_v[0]) + int'(dn_v[0]);
      nx();
    end
    sin = 0;
    chk("rx early pulses", pulses, 0);
    chk("rx po_valid", pv_v, 2'b11);
    chk("rx done", dn_v, 2'b11);
    chk("rx pout_l", pout_l, 8'h96);
    chk("rx pout_m", pout_m, 8'h69);
    nx();
    chk("rx po_valid drop", pv_v, 0);
    chk("rx done drop", dn_v, 0);
    chk("rx pout held", pout_l, 8'h96);
    // MSB-first transmit of C3
    w = 8'hC3; pin = w; tx_start = 1;
    nx();
    tx_start = 0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("msb tx%0d so", k), so_v[1], w[7-k]);
      chk($sformatf("msb tx%0d so_valid", k), sv_v[1], 1);
      nx();
    end
    chk("msb tx end busy", bz_v[1], 0);
    // simultaneous start picks TX; rx_start mid-frame is ignored
    pin = 8'hA5; tx_start = 1; rx_start = 1;
    nx();
    tx_start = 0; rx_start = 0;
    chk("both start so_valid", sv_v[0], 1);
    chk("both start pout", pout_l, 8'hA5);
    n = 0;
    for (int c = 0; c < 20 && sv_v[0] === 1'b1; c++) begin
      rx_start = c == 2;
      n++;
      nx();
    end
    rx_start = 0;
    chk("busy start so_valid cycles", n, 8);
    chk("busy start no rx", bz_v, 0);
    // abort at the 4th TX cycle
    pin = 8'hA5; tx_start = 1;
    nx();
    tx_start = 0; pulses = 0;
    for (int k = 0; k < 3; k++) begin
      pulses += int'(dn_v[0]);
      nx();
    end
    abort = 1;
    #1;
    pulses += int'(dn_v[0]);
    chk("abort pre pout", pout_l, 8'h14);
    nx();
    abort = 0;
    pulses += int'(dn_v[0]);
    chk("abort busy", bz_v, 0);
    chk("abort pout held", pout_l, 8'h14);
    chk("abort so_valid", sv_v, 0);
    nx();
    pulses += int'(dn_v[0]);
    chk("abort no done", pulses, 0);
    chk("abort idle pout", pout_l, 8'h14);
    // asynchronous reset in the middle of RX
    rx_start = 1; sin = 1;
    nx();
    rx_start = 0;
    nx();
    nx();
    chk("mid rx busy", bz_v, 2'b11);
    #2;
    rst = 1;
    #1;
    chk("arst pout_l", pout_l, 0);
    chk("arst pout_m", pout_m, 0);
    chk("arst busy", bz_v, 0);
    chk("arst so", so_v, 0);
    chk("arst flags", {sv_v, pv_v, dn_v}, 0);
    nx();
    rst = 0; sin = 0;
    nx();
    chk("arst no po_valid", pv_v, 0);
    chk("arst idle", bz_v, 0);
    // random stimulus against a frame-level model of both bit orders
    rst = 1;
    nx();
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mm[i] = 0; mk[i] = 0; mp[i] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      tx_start = $urandom_range(0, 7) == 0;
      rx_start = $urandom_range(0, 7) == 0;
      abort = $urandom_range(0, 15) == 0;
      op = 3'($urandom);
      pin = 8'($urandom);
      sin = 1'($urandom);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rnd%0d.%0d pout", c, i), i ? pout_m : pout_l, mq[i]);
        chk($sformatf("rnd%0d.%0d so", c, i), so_v[i], i ? mq[i][7] : mq[i][0]);
        chk($sformatf("rnd%0d.%0d so_valid", c, i), sv_v[i], mm[i] == 1);
        chk($sformatf("rnd%0d.%0d busy", c, i), bz_v[i], mm[i] != 0);
        chk($sformatf("rnd%0d.%0d po_valid", c, i), pv_v[i], mp[i]);
        chk($sformatf("rnd%0d.%0d done", c, i), dn_v[i],
            mp[i] || (mm[i] == 1 && mk[i] == 7 && !abort));
      end
      for (int i = 0; i < 2; i++) begin
        mp[i] = 0;
        if (mm[i] == 0) begin
          if (tx_start) begin
            mq[i] = pin; mm[i] = 1; mk[i] = 0;
          end else if (rx_start) begin
            mm[i] = 2; mk[i] = 0;
          end else begin
            case (op)
              3'd1: mq[i] = pin;
              3'd2: mq[i] = (mq[i] >> 1) | (8'(sin) << 7);
              3'd3: mq[i] = (mq[i] << 1) | 8'(sin);
              3'd4: mq[i] = (mq[i] >> 1) | (mq[i] << 7);
              3'd5: mq[i] = (mq[i] << 1) | (mq[i] >> 7);
              3'd6: mq[i] = 0;
              default: ;
            endcase
          end
        end else if (abort) begin
          mm[i] = 0;
        end else begin
          if (mm[i] == 1) mq[i] = i ? mq[i] << 1 : mq[i] >> 1;
          else mq[i] = i ? (mq[i] << 1) | 8'(sin) : (mq[i] >> 1) | (8'(sin) << 7);
          mk[i]++;
          if (mk[i] == 8) begin
            mp[i] = mm[i] == 2;
            mm[i] = 0;
          end
        end
      end
      @(posedge clk);
      #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/univ_shreg_ctrl.md
Name: univ_shreg_ctrl

Overview:
Parametrised universal shift register with a built-in serial transmit/receive sequencer. It generalises the 4-bit PISO/SISO/SIPO/PIPO registers to WIDTH bits. It adds left/right shift, rotate and clear, plus counted frame transfers with valid/done strobes. It is the common serial/parallel conversion block for the practice designs' datapaths.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- LSB_FIRST, 1, 1 = serial frames move LSB first (shift right); 0 = MSB first (shift left).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- op  in  3  direct op, honoured only in IDLE when no start is asserted: 000 HOLD, 001 LOAD, 010 SHR, 011 SHL, 100 ROR, 101 ROL, 110 CLR, 111 HOLD
- pin  in  WIDTH  parallel data in
- sin  in  1  serial data in
- tx_start  in  1  begin serial transmit of pin
- rx_start  in  1  begin serial receive of WIDTH bits
- abort  in  1  cancel an active frame
- pout  out  WIDTH  register contents, always q
- so  out  1  serial out
- so_valid  out  1  so carries a frame bit
- po_valid  out  1  one-cycle pulse: pout holds a completed received frame
- done  out  1  one-cycle pulse at frame completion (TX or RX)
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: q=0, state=IDLE, cnt=0. so_valid, po_valid, done and busy are all 0. so=0 because q=0.
- Direct ops (IDLE only), applied at the clock edge:
  - SHR: q={sin,q[W-1:1]}.
  - SHL: q={q[W-2:0],sin}.
  - ROR: q={q[0],q[W-1:1]}.
  - ROL: q={q[W-2:0],q[W-1]}.
  - LOAD: q=pin.
  - CLR: q=0.
  - HOLD and 111: q unchanged.
- Serial out: so = q[0] if LSB_FIRST, else q[W-1]. It is combinational from q. so_valid = (state==TX).
- FSM states: IDLE, TX, RX.
- IDLE with tx_start:
  - q<=pin, cnt<=WIDTH, state<=TX.
  - tx_start has priority over rx_start and op.
- IDLE with rx_start (tx_start=0):
  - cnt<=WIDTH, state<=RX. q is unchanged.
- TX:
  - Each cycle, shift toward the so end: SHR if LSB_FIRST, else SHL. Shift-in is 0.
  - cnt decrements each cycle.
  - On the cycle with cnt==1: done<=1 and state<=IDLE.
  - so_valid is high for exactly WIDTH cycles. Frame bit k appears k cycles after TX entry.
- RX:
  - Each cycle, sample sin: SHR (sin into MSB) if LSB_FIRST, else SHL (sin into LSB).
  - cnt decrements each cycle.
  - On the cycle with cnt==1 the final bit is shifted in, and po_valid<=1, done<=1, state<=IDLE.
  - The first bit sampled arrives at bit 0 (LSB_FIRST) or bit W-1 (MSB_FIRST) of the final word.
- Pulses: po_valid and done are high for exactly one cycle.
- Starts ignored while busy: tx_start and rx_start have no effect in TX or RX. op is ignored while busy.
- abort in TX or RX:
  - state<=IDLE, cnt<=0, no shift that cycle, q held.
  - No done or po_valid pulse.
  - abort in IDLE has no effect.
- Mid-frame reset: rst asserted mid-frame forces all reset values immediately, with no pulse.
- Counter width is $clog2(WIDTH+1) and never underflows.
- Latency:
  - TX start to first so_valid is 1 cycle.
  - RX start to first sample is 1 cycle.
  - The last sample and the po_valid pulse occur on the same edge.

Decomposition:
- Package univ_shreg_pkg holds:
  - op_e enum (OP_HOLD..OP_CLR) with 3-bit encodings.
  - state_e enum {S_IDLE,S_TX,S_RX}.
- Sub-module shreg_core(WIDTH) holds the pure datapath:
  - inputs: op_e, pin, sin; register q.
  - The FSM in univ_shreg_ctrl drives its op (LOAD/SHR/SHL/HOLD).

Test Plan:
- Reset then direct ops (WIDTH=8), in order:
  - LOAD pin=8'h81 -> pout=8'h81.
  - ROL -> 8'h03.
  - SHR with sin=1 -> 8'h81.
  - SHL with sin=0 -> 8'h02.
  - CLR -> 8'h00.
- TX, LSB_FIRST=1, pin=8'hA5, pulse tx_start:
  - Next 8 cycles: so_valid=1 and so=1,0,1,0,0,1,0,1.
  - done pulses in the 8th so_valid cycle.
  - busy=0 afterwards.
- RX, LSB_FIRST=1, sin stream 0,1,1,0,1,0,0,1 after rx_start:
  - po_valid and done pulse once with pout=8'h96.
- MSB_FIRST instance, TX pin=8'hC3:
  - so=1,1,0,0,0,0,1,1.
- Simultaneous and busy starts:
  - tx_start and rx_start in the same cycle -> TX taken.
  - rx_start during TX -> ignored; exactly 8 so_valid cycles.
- Abort and mid-frame reset:
  - abort at the 4th TX cycle -> IDLE next edge, no done, pout holds partially shifted value.
  - rst asserted mid-RX -> pout=0 and all outputs 0 immediately (asynchronous), no po_valid.
